// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam int unsigned DEF_MEM_DEPTH = 256;

  // True when a word address falls inside the memory.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_done;
  logic          p0_err;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_done;
  logic          p1_err;
  logic [DW-1:0] p1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_done, p0_err, p0_rdata,
    output p1_gnt, p1_done, p1_err, p1_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_done, p0_err, p0_rdata,
    input  p1_gnt, p1_done, p1_err, p1_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way picker: one-hot grant, ties go to the port that did not win last.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_AUX) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory (grant, then response).
// Macro DMEM_ARB_RR_EN selects round-robin arbitration; fixed priority (port 0) otherwise.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;

  logic [1:0]    req;
  logic [1:0]    pick;
  logic          last_win;

  logic          win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          in_range;
  logic          grant;

  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;

  assign req = {bus.p1_req, bus.p0_req};

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT_AUX;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = win;
    end
  end

  assign last_win = last_q;
`else
  assign last_win = PORT_AUX;
`endif

  dmem_arb_pick u_pick (
    .req_i  (req),
    .last_i (last_win),
    .gnt_o  (pick)
  );

  always_comb begin
    win       = pick[PORT_AUX];
    sel_addr  = (win == PORT_AUX) ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = (win == PORT_AUX) ? bus.p1_wdata : bus.p0_wdata;
    sel_we    = (win == PORT_AUX) ? bus.p1_we    : bus.p0_we;
    in_range  = addr_in_range(64'(sel_addr), MEM_DEPTH);
  end

  // Grants are suppressed while reset is held so every output reads 0 during reset.
  assign grant = (state_q == ST_IDLE) && !reset && (|pick);

  assign resp_data = (we_q || oor_q) ? '0 : bus.mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      win_q   <= PORT_CORE;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    oor_d     = oor_q;
    gnt       = '0;
    done      = '0;
    err       = '0;
    rdata0    = '0;
    rdata1    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          gnt       = pick;
          mem_addr  = sel_addr;
          mem_wdata = sel_wdata;
          mem_we    = sel_we && in_range;
          mem_re    = !sel_we && in_range;
          win_d     = win;
          we_d      = sel_we;
          oor_d     = !in_range;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        done[win_q] = 1'b1;
        err[win_q]  = oor_q;
        if (win_q == PORT_AUX) begin
          rdata1 = resp_data;
        end else begin
          rdata0 = resp_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.p0_gnt    = gnt[PORT_CORE];
  assign bus.p1_gnt    = gnt[PORT_AUX];
  assign bus.p0_done   = done[PORT_CORE];
  assign bus.p1_done   = done[PORT_AUX];
  assign bus.p0_err    = err[PORT_CORE];
  assign bus.p1_err    = err[PORT_AUX];
  assign bus.p0_rdata  = rdata0;
  assign bus.p1_rdata  = rdata1;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the processor's single-port data memory (256 × 32-bit words, word-addressed, registered read, write-over-read priority). It shares the memory between the core load/store unit (port 0) and a secondary master such as a DMA or debug loader (port 1). It serialises their requests into a two-cycle grant/response sequence and drives the memory's `Address`, `DataIn`, `ReadEnable` and `WriteEnable` inputs. It returns read data, completion and error to the winning requester.

## Interface
- `MEM_DEPTH`, 256, number of 32-bit words in the data memory; legal word addresses are 0..MEM_DEPTH-1.
- `AW`, 32, requester and memory address width.
- `DW`, 32, data width.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `p0_req`, `p1_req` input 1: request; held high until the matching `gnt`.
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read; stable while `req` is high.
- `p0_addr`, `p1_addr` input AW: word address; stable while `req` is high.
- `p0_wdata`, `p1_wdata` input DW: write data; stable while `req` is high.
- `p0_gnt`, `p1_gnt` output 1: one-cycle pulse; the request is accepted at this clock edge.
- `p0_done`, `p1_done` output 1: one-cycle completion pulse, in the cycle after `gnt`.
- `p0_err`, `p1_err` output 1: qualified by `done`; 1 = address out of range.
- `p0_rdata`, `p1_rdata` output DW: read data, valid while `done` is high and `we` was 0.
- `mem_addr` output AW: drives memory `Address`.
- `mem_wdata` output DW: drives memory `DataIn`.
- `mem_re` output 1: drives memory `ReadEnable`.
- `mem_we` output 1: drives memory `WriteEnable`.
- `mem_rdata` input DW: from memory `DataOut`.

## Operation
- FSM states:
  - IDLE: arbitration allowed.
  - RESP: the response cycle for the transaction accepted at the previous edge.
- In IDLE with at least one `req` high:
  - Pick a winner and assert its `gnt` combinationally.
  - Drive the winner's `addr` and `wdata` onto `mem_addr` and `mem_wdata`.
  - Assert `mem_we` (write) or `mem_re` (read).
  - Latch the winner index, the `we` value and a range flag.
  - Move to RESP.
- In RESP:
  - Pulse the winner's `done`.
  - For a read, route `mem_rdata` to the winner's `rdata`; for a write, `rdata` = 0.
  - `mem_re` and `mem_we` are 0; no grant is issued; return to IDLE.
- Out of range (`addr` ≥ MEM_DEPTH):
  - `gnt` is still given, but `mem_re`/`mem_we` stay 0, so memory is untouched.
  - In RESP: `done`=1, `err`=1, `rdata`=0.
- Arbitration without the macro: fixed priority, port 0 wins.
- Non-winning requester keeps `req` high and is reconsidered at the next IDLE cycle.
- `mem_addr` and `mem_wdata` are 0 whenever no grant is active.

## Timing
- Reset values:
  - State IDLE.
  - All `gnt`, `done`, `err` = 0; all `rdata` = 0.
  - `mem_re`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
  - Round-robin pointer = last-winner port 1.
- Latency: `gnt` in cycle N, `done`/`rdata` in cycle N+1.
- Throughput: one transaction per 2 cycles; the earliest next grant is cycle N+2.
- Simultaneous requests in IDLE: exactly one `gnt` per cycle; never both.
- Requester deasserting `req` before `gnt`: the request is withdrawn, with no side effect.
- Reset asserted in RESP: `done` for the pending transaction is never issued. A write granted before reset has already committed in memory.
- `req` raised during RESP is not granted until the following IDLE cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration; on a tie, the port that did not win last is granted.
  - The last-winner pointer updates on every `gnt`.
- `DMEM_ARB_RR_EN` undefined:
  - Fixed priority, port 0 always first.
  - No pointer register exists.

## Structure
- Package `dmem_arb_pkg` holds:
  - The state enum (IDLE, RESP).
  - Port index constants `PORT_CORE`=0 and `PORT_AUX`=1.
  - The default `MEM_DEPTH`.
- One sub-module, `dmem_arb_pick`: a combinational 2-way picker taking `req[1:0]` and the last winner, producing one-hot `gnt[1:0]`. It is compiled in both modes; in fixed mode the last-winner input is tied to 1.
- The top level holds the FSM, the latched winner/`we`/range flag, and the muxing.

## Test plan
Memory is pre-initialised so that word i holds i.
- Reset, then p0 reads address 7 → `p0_gnt` in cycle 1, `p0_done`=1 and `p0_rdata`=0x00000007 in cycle 2, `p0_err`=0.
- p1 writes 0xDEADBEEF to address 10, then p1 reads address 10 → read returns 0xDEADBEEF; `gnt` pulses are 2 cycles apart.
- p0 and p1 both request continuously:
  - Fixed mode: p0 is granted every IDLE cycle and p1 never.
  - With `DMEM_ARB_RR_EN`: grants alternate, p0 first (0,1,0,1).
- p0 writes to address 300 → `gnt`=1, `mem_we` stays 0, then `done`=1, `err`=1, `rdata`=0; a later read of address 300 mod 256 = 44 still returns 44.
- Reset asserted in RESP after a p1 read grant → `p1_done` never pulses; all outputs are 0 immediately; a new p0 request after reset completes normally.
- p0 raises `req` during p1's RESP cycle → `p0_gnt` arrives exactly one cycle later, in IDLE.
